gelato_warp_scheduler: RTL and testbench

//  Issue-side warp scheduler. Sits between the per-warp instruction buffers and the dispatch/issue stage.

---
 rtl/gelato_types_pkg.sv | 30 +++
 rtl/gelato_rr_arbiter.sv | 35 +++
 rtl/gelato_warp_scheduler.sv | 136 +++++++++++++
 tb/tb_gelato_warp_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_types_pkg.sv
// Shared scheduler types: per-warp lifecycle states, the instruction word,
// and a round-robin wrap helper.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

package gelato_types;

    localparam int WARP_ID_W = $clog2(`WARP_NUM);

    typedef enum logic [1:0] {
        WARP_INACTIVE = 2'd0,
        WARP_ACTIVE   = 2'd1,
        WARP_PENDING  = 2'd2
    } warp_state_e;

    typedef struct packed {
        logic [7:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [8:0] imm;
    } inst_t;

    // Index k positions after base in a ring of n entries.
    function automatic int rr_wrap(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr wins,
// wrapping modulo N. gnt is suppressed when en is low; any ignores en.
module gelato_rr_arbiter
    import gelato_types::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        found   = 1'b0;
        cand    = '0;
        gnt_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'(rr_wrap(int'(ptr), k, N));
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        any = |req;
        gnt = (en && found) ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Issue-side warp scheduler: round-robin pick of one eligible warp per cycle
// into a one-entry issue register. Optional perf counters: GELATO_SCHED_PERF_EN.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

module gelato_warp_scheduler
    import gelato_types::*;
#(
    parameter int WARP_NUM  = `WARP_NUM,
    parameter int WARP_ID_W = $clog2(WARP_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  launch_valid,
    input  logic [WARP_ID_W-1:0]  launch_warp,
    input  logic [WARP_NUM-1:0]   buf_valid,
    input  inst_t [WARP_NUM-1:0]  buf_inst,
    output logic [WARP_NUM-1:0]   buf_caught,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output inst_t                 issue_inst,
    output logic [WARP_ID_W-1:0]  issue_warp,
    input  logic                  commit_valid,
    input  logic [WARP_ID_W-1:0]  commit_warp,
    input  logic                  commit_exit,
    output logic [WARP_NUM-1:0]   warp_active,
    output logic [31:0]           perf_issue_cnt,
    output logic [31:0]           perf_stall_cnt
);

    logic [WARP_NUM-1:0]  eligible;
    logic [WARP_NUM-1:0]  gnt;
    logic [WARP_ID_W-1:0] gnt_idx;
    logic                 any_eligible;
    logic                 slot_free;
    logic                 select;

    logic                 issue_valid_reg;
    inst_t                issue_inst_reg;
    logic [WARP_ID_W-1:0] issue_warp_reg;
    logic [WARP_ID_W-1:0] rr_ptr_reg;

    assign slot_free  = !issue_valid_reg || issue_ready;
    assign select     = rdy && slot_free && any_eligible;
    assign buf_caught = gnt;

    gelato_rr_arbiter #(.N(WARP_NUM), .IW(WARP_ID_W)) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr_reg),
        .en      (rdy && slot_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_eligible)
    );

    // Launch only lands on INACTIVE and commit only on PENDING, so at most one
    // of launch/select/commit is legal for a given warp in any cycle.
    genvar gi;
    generate
        for (gi = 0; gi < WARP_NUM; gi++) begin : g_warp
            warp_state_e state_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= WARP_INACTIVE;
                end else begin
                    case (state_reg)
                        WARP_INACTIVE:
                            if (launch_valid && launch_warp == WARP_ID_W'(gi))
                                state_reg <= WARP_ACTIVE;
                        WARP_ACTIVE:
                            if (select && gnt[gi])
                                state_reg <= WARP_PENDING;
                        WARP_PENDING:
                            if (commit_valid && commit_warp == WARP_ID_W'(gi))
                                state_reg <= commit_exit ? WARP_INACTIVE : WARP_ACTIVE;
                        default:
                            state_reg <= WARP_INACTIVE;
                    endcase
                end
            end

            assign eligible[gi]    = (state_reg == WARP_ACTIVE) && buf_valid[gi];
            assign warp_active[gi] = (state_reg != WARP_INACTIVE);
        end
    endgenerate

    // Payload is held whenever the slot is occupied and not accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_reg <= 1'b0;
            issue_inst_reg  <= '0;
            issue_warp_reg  <= '0;
            rr_ptr_reg      <= WARP_ID_W'(WARP_NUM - 1);
        end else if (slot_free) begin
            if (select) begin
                issue_valid_reg <= 1'b1;
                issue_inst_reg  <= buf_inst[gnt_idx];
                issue_warp_reg  <= gnt_idx;
                rr_ptr_reg      <= gnt_idx;
            end else begin
                issue_valid_reg <= 1'b0;
            end
        end
    end

    assign issue_valid = issue_valid_reg;
    assign issue_inst  = issue_inst_reg;
    assign issue_warp  = issue_warp_reg;

`ifdef GELATO_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt_reg;
    logic [31:0] perf_stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt_reg <= '0;
            perf_stall_cnt_reg <= '0;
        end else begin
            if (issue_valid_reg && issue_ready)
                perf_issue_cnt_reg <= perf_issue_cnt_reg + 32'd1;
            if (issue_valid_reg && !issue_ready)
                perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
        end
    end

    assign perf_issue_cnt = perf_issue_cnt_reg;
    assign perf_stall_cnt = perf_stall_cnt_reg;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Self-checking bench for gelato_warp_scheduler: directed phases plus random
// traffic, all checked against a per-warp behavioural model every cycle.
module tb_gelato_warp_scheduler;
    import gelato_types::inst_t;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          launch_valid;
    logic [IW-1:0] launch_warp;
    logic [N-1:0]  buf_valid;
    inst_t [N-1:0] buf_inst;
    logic [N-1:0]  buf_caught;
    logic          issue_valid;
    logic          issue_ready;
    inst_t         issue_inst;
    logic [IW-1:0] issue_warp;
    logic          commit_valid;
    logic [IW-1:0] commit_warp;
    logic          commit_exit;
    logic [N-1:0]  warp_active;
    logic [31:0]   perf_issue_cnt;
    logic [31:0]   perf_stall_cnt;

    gelato_warp_scheduler #(.WARP_NUM(N), .WARP_ID_W(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .launch_valid   (launch_valid),
        .launch_warp    (launch_warp),
        .buf_valid      (buf_valid),
        .buf_inst       (buf_inst),
        .buf_caught     (buf_caught),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_inst     (issue_inst),
        .issue_warp     (issue_warp),
        .commit_valid   (commit_valid),
        .commit_warp    (commit_warp),
        .commit_exit    (commit_exit),
        .warp_active    (warp_active),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a warp is launched (active) and possibly has one instruction in flight.
    bit          m_launched [N];
    bit          m_inflight [N];
    int          m_last;
    bit          m_valid;
    inst_t       m_inst;
    int          m_warp;
    int unsigned m_icnt;
    int unsigned m_scnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_launched[i] = 1'b0;
            m_inflight[i] = 1'b0;
        end
        m_last  = N - 1;
        m_valid = 1'b0;
        m_inst  = '0;
        m_warp  = 0;
        m_icnt  = 0;
        m_scnt  = 0;
    endtask

    task automatic idle_inputs();
        rdy          = 1'b1;
        launch_valid = 1'b0;
        launch_warp  = '0;
        commit_valid = 1'b0;
        commit_warp  = '0;
        commit_exit  = 1'b0;
        issue_ready  = 1'b1;
        buf_valid    = '0;
        for (int i = 0; i < N; i++) buf_inst[i] = inst_t'($urandom);
    endtask

    task automatic rand_inputs();
        rdy          = ($urandom_range(0, 9) != 0);
        issue_ready  = ($urandom_range(0, 9) < 7);
        buf_valid    = N'($urandom);
        launch_valid = ($urandom_range(0, 3) == 0);
        launch_warp  = IW'($urandom_range(0, N - 1));
        commit_valid = ($urandom_range(0, 1) == 0);
        commit_warp  = IW'($urandom_range(0, N - 1));
        commit_exit  = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < N; i++) buf_inst[i] = inst_t'($urandom);
    endtask

    // Called right after inputs are driven at a falling edge.
    task automatic step();
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_act;
        int  sel;
        bit  free;
        bit  do_launch;
        bit  do_commit;
        #1;
        free = !m_valid || issue_ready;
        sel  = -1;
        if (rdy && free) begin
            for (int k = 1; k <= N; k++) begin
                int w;
                w = (m_last + k) % N;
                if (sel < 0 && m_launched[w] && !m_inflight[w] && buf_valid[w]) sel = w;
            end
        end
        exp_gnt = '0;
        if (sel >= 0) exp_gnt[sel] = 1'b1;
        for (int i = 0; i < N; i++) exp_act[i] = m_launched[i];

        check_eq("buf_caught", 64'(buf_caught), 64'(exp_gnt));
        check_eq("issue_valid", 64'(issue_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("issue_inst", 64'(issue_inst), 64'(m_inst));
            check_eq("issue_warp", 64'(issue_warp), 64'(m_warp));
        end
        check_eq("warp_active", 64'(warp_active), 64'(exp_act));
`ifdef GELATO_SCHED_PERF_EN
        check_eq("perf_issue_cnt", 64'(perf_issue_cnt), 64'(m_icnt));
        check_eq("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_scnt));
`else
        check_eq("perf_issue_cnt", 64'(perf_issue_cnt), 64'd0);
        check_eq("perf_stall_cnt", 64'(perf_stall_cnt), 64'd0);
`endif
        $display("cyc t=%0t rdy=%0b bv=%b caught=%b iv=%0b iw=%0d ir=%0b act=%b", $time,
                 rdy, buf_valid, buf_caught, issue_valid, issue_warp, issue_ready, warp_active);

        @(posedge clk);
        if (m_valid && issue_ready)  m_icnt++;
        if (m_valid && !issue_ready) m_scnt++;
        do_launch = launch_valid && !m_launched[launch_warp];
        do_commit = commit_valid && m_inflight[commit_warp];
        if (do_launch) m_launched[launch_warp] = 1'b1;
        if (do_commit) begin
            m_inflight[commit_warp] = 1'b0;
            if (commit_exit) m_launched[commit_warp] = 1'b0;
        end
        if (sel >= 0) begin
            m_inflight[sel] = 1'b1;
            m_last  = sel;
            m_valid = 1'b1;
            m_inst  = buf_inst[sel];
            m_warp  = sel;
        end else if (free) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_issue_valid"}, 64'(issue_valid), 64'd0);
        check_eq({tag, "_issue_inst"},  64'(issue_inst),  64'd0);
        check_eq({tag, "_issue_warp"},  64'(issue_warp),  64'd0);
        check_eq({tag, "_buf_caught"},  64'(buf_caught),  64'd0);
        check_eq({tag, "_warp_active"}, 64'(warp_active), 64'd0);
        check_eq({tag, "_perf_issue"},  64'(perf_issue_cnt), 64'd0);
        check_eq({tag, "_perf_stall"},  64'(perf_stall_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        buf_valid = '1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Launch 0..3 with full buffers; commit whatever sits in the issue register.
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            buf_valid = '1;
            if (c < N) begin
                launch_valid = 1'b1;
                launch_warp  = IW'(c);
            end
            if (m_valid) begin
                commit_valid = 1'b1;
                commit_warp  = IW'(m_warp);
            end
            step();
        end

        // Only warp 2 has work; its commit is withheld for ten cycles.
        for (int c = 0; c < 14; c++) begin
            idle_inputs();
            buf_valid = 4'b0100;
            if (c == 10 && m_inflight[2]) begin
                commit_valid = 1'b1;
                commit_warp  = 2'd2;
            end
            step();
        end

        // Downstream stall for five cycles.
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            buf_valid   = '1;
            issue_ready = (c >= 5);
            for (int w = 0; w < N; w++)
                if (m_inflight[w] && !(m_valid && m_warp == w)) begin
                    commit_valid = 1'b1;
                    commit_warp  = IW'(w);
                end
            step();
        end

        // Global disable while commits keep arriving.
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            buf_valid = '1;
            rdy       = (c >= 4);
            commit_valid = 1'b1;
            commit_warp  = IW'(c % N);
            step();
        end

        // Exit warp 0, re-launch it, and try launching an already-active warp 1.
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            buf_valid = 4'b0001;
            if (m_inflight[0]) begin
                commit_valid = 1'b1;
                commit_warp  = 2'd0;
                commit_exit  = (c < 5);
            end else if (!m_launched[0]) begin
                launch_valid = 1'b1;
                launch_warp  = 2'd0;
            end else begin
                launch_valid = 1'b1;
                launch_warp  = 2'd1;
            end
            step();
        end

        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            step();
        end

        // Asynchronous reset in mid-cycle with traffic in flight.
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            buf_valid   = '1;
            issue_ready = 1'b0;
            launch_valid = 1'b1;
            launch_warp  = IW'(c % N);
            step();
        end
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            buf_valid = '1;
            if (c < N) begin
                launch_valid = 1'b1;
                launch_warp  = IW'(N - 1 - c);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
